// File: rtl/randa_pkg.sv
// Shared definitions for the randa test-stream blocks: FSM states and LFSR constants.
package randa_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP
  } state_t;

  localparam logic [15:0] LFSR_TAPS     = 16'hB400;
  localparam logic [15:0] LFSR_DEF_SEED = 16'hACE1;

  // One step of the 16-bit right-shifting Galois LFSR.
  function automatic logic [15:0] lfsr_step(input logic [15:0] q);
    return {1'b0, q[15:1]} ^ (q[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/stream_src_if.sv
// Valid/ready/last stream bundle between a randa source and its sink.
interface stream_src_if #(
  parameter int LEN = 8
) ();
  logic           valid_out;
  logic [LEN-1:0] data_out;
  logic           last_out;
  logic           ready_in;

  modport master (output valid_out, output data_out, output last_out, input ready_in);
  modport slave  (input valid_out, input data_out, input last_out, output ready_in);
endinterface

// File: rtl/randa_lfsr16.sv
// 16-bit Galois LFSR with synchronous load-on-reset and a step enable.
module randa_lfsr16
  import randa_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  // An all-zero state would lock up the LFSR, so a zero seed falls back to the default.
  logic [15:0] seed_eff;
  assign seed_eff = (seed == 16'h0000) ? LFSR_DEF_SEED : seed;

  always_ff @(posedge clk) begin
    if (rst)       q <= seed_eff;
    else if (step) q <= lfsr_step(q);
  end

endmodule

// File: rtl/stream_src.sv
// Framed test-stream source: sequence-counter payload, LFSR-driven inter-packet gaps.
module stream_src
  import randa_pkg::*;
#(
  parameter int          LEN     = 8,
  parameter int          PKT_LEN = 4,
  parameter int          GAP_W   = 3,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  stream_src_if.master        strm,
  output logic [15:0]         pkt_count,
  output logic                busy
);

  localparam int            BW        = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(PKT_LEN - 1);
  localparam logic          ONE_BEAT  = (PKT_LEN == 1);

  state_t           state;
  logic [BW-1:0]    beat;
  logic [BW-1:0]    beat_inc;
  logic [LEN-1:0]   seq;
  logic [LEN-1:0]   seq_inc;
  logic [GAP_W-1:0] gap_cnt;
  logic [GAP_W-1:0] gap_next;
  logic [15:0]      lfsr_q;
  logic             xfer;
  logic             last_xfer;

  assign xfer      = strm.valid_out && strm.ready_in;
  assign last_xfer = xfer && strm.last_out;
  assign beat_inc  = beat + 1'b1;
  assign seq_inc   = seq + 1'b1;
  assign busy      = (state != S_IDLE);

  // Low bits of the LFSR's next state, formed directly from the current state.
  assign gap_next = lfsr_q[GAP_W:1] ^ (lfsr_q[0] ? LFSR_TAPS[GAP_W-1:0] : '0);

  randa_lfsr16 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .step (last_xfer),
    .seed (SEED),
    .q    (lfsr_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      beat           <= '0;
      seq            <= '0;
      gap_cnt        <= '0;
      pkt_count      <= '0;
      strm.valid_out <= 1'b0;
      strm.data_out  <= '0;
      strm.last_out  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (enable) begin
            state          <= S_SEND;
            beat           <= '0;
            strm.valid_out <= 1'b1;
            strm.data_out  <= seq;
            strm.last_out  <= ONE_BEAT;
          end
        end
        S_SEND: begin
          if (xfer) begin
            seq <= seq_inc;
            if (!strm.last_out) begin
              beat          <= beat_inc;
              strm.data_out <= seq_inc;
              strm.last_out <= (beat_inc == LAST_BEAT);
            end else begin
              pkt_count <= pkt_count + 16'd1;
              beat      <= '0;
              if (gap_next == '0 && enable) begin
                strm.data_out <= seq_inc;
                strm.last_out <= ONE_BEAT;
              end else begin
                state          <= (gap_next == '0) ? S_IDLE : S_GAP;
                gap_cnt        <= gap_next;
                strm.valid_out <= 1'b0;
                strm.last_out  <= 1'b0;
              end
            end
          end
        end
        S_GAP: begin
          // Leaving on count==1 makes the idle span exactly gap_next cycles.
          if (gap_cnt == GAP_W'(1)) begin
            if (enable) begin
              state          <= S_SEND;
              beat           <= '0;
              strm.valid_out <= 1'b1;
              strm.data_out  <= seq;
              strm.last_out  <= ONE_BEAT;
            end else begin
              state <= S_IDLE;
            end
          end
          gap_cnt <= gap_cnt - 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_src.sv
// Directed bench for stream_src: sink-side scoreboard with an independent LFSR gap model.
module tb_stream_src;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] pkt_count;
  logic        busy;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  stream_src_if #(.LEN(8)) s ();

  stream_src #(
    .LEN     (8),
    .PKT_LEN (4),
    .GAP_W   (3),
    .SEED    (16'hACE1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .strm      (s),
    .pkt_count (pkt_count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  logic [7:0]  exp_seq;
  int          exp_beat;
  int          exp_pkt;
  logic [15:0] m_lfsr;
  int          exp_gap;
  int          idle;
  bit          track;

  function automatic logic [15:0] model_step(input logic [15:0] v);
    if (v[0]) return (v >> 1) ^ 16'hB400;
    return v >> 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_seq  = 8'd0;
    exp_beat = 0;
    exp_pkt  = 0;
    m_lfsr   = 16'hACE1;
    exp_gap  = 0;
    idle     = 0;
    track    = 1'b0;
  endtask

  // Called just after an edge: drive ready, score the beat that the next edge will take.
  task automatic sink_cycle(input logic rdy);
    s.ready_in = rdy;
    if (s.valid_out && track) begin
      check("gap_len", idle, exp_gap);
      track = 1'b0;
    end
    if (s.valid_out && rdy) begin
      check("data", {24'd0, s.data_out}, {24'd0, exp_seq});
      check("last", {31'd0, s.last_out}, {31'd0, exp_beat == 3});
      exp_seq = exp_seq + 8'd1;
      if (exp_beat == 3) begin
        exp_beat = 0;
        exp_pkt++;
        m_lfsr  = model_step(m_lfsr);
        exp_gap = int'(m_lfsr[2:0]);
        idle    = 0;
        track   = enable;
      end else begin
        exp_beat++;
      end
    end else if (!s.valid_out) begin
      idle++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc;
    int seq_before;
    int pkt_before;

    rst        = 1'b1;
    enable     = 1'b1;
    s.ready_in = 1'b1;
    model_reset();

    // Reset held for three edges with active inputs.
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, s.valid_out}, 32'd0);
    check("rst_last",  {31'd0, s.last_out},  32'd0);
    check("rst_data",  {24'd0, s.data_out},  32'd0);
    check("rst_pkt",   {16'd0, pkt_count},   32'd0);
    check("rst_busy",  {31'd0, busy},        32'd0);

    // First packet: one-cycle start latency, then 0..3 back to back.
    rst = 1'b0;
    check("pre_start_valid", {31'd0, s.valid_out}, 32'd0);
    @(posedge clk);
    #1;
    check("start_valid", {31'd0, s.valid_out}, 32'd1);
    check("start_data",  {24'd0, s.data_out},  32'd0);
    check("start_busy",  {31'd0, busy},        32'd1);
    repeat (4) sink_cycle(1'b1);
    check("pkt1_count", {16'd0, pkt_count}, 32'd1);
    // First gap from seed ACE1 is 0, so the next packet follows immediately.
    check("pkt2_valid", {31'd0, s.valid_out}, 32'd1);
    check("pkt2_data",  {24'd0, s.data_out},  32'd4);

    // Backpressure on beat 2 of packet 2.
    cyc = 0;
    while (!(s.valid_out && s.data_out == 8'd6) && cyc < 50) begin
      sink_cycle(1'b1);
      cyc++;
    end
    check("wait_data6", {31'd0, cyc < 50}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", {31'd0, s.valid_out}, 32'd1);
      check("stall_data",  {24'd0, s.data_out},  32'd6);
      check("stall_last",  {31'd0, s.last_out},  32'd0);
      sink_cycle(1'b0);
    end
    check("post_stall_data", {24'd0, s.data_out}, 32'd6);

    // Random backpressure until 300 packets have completed in total.
    cyc = 0;
    while (exp_pkt < 300 && cyc < 20000) begin
      sink_cycle(1'($urandom_range(0, 1)));
      cyc++;
    end
    check("rand_done",  {31'd0, exp_pkt == 300}, 32'd1);
    check("rand_count", {16'd0, pkt_count},      32'd300);

    // Drop enable during beat 1: the packet still completes, then the source stops.
    cyc = 0;
    while (!(s.valid_out && exp_beat == 1) && cyc < 100) begin
      sink_cycle(1'b1);
      cyc++;
    end
    check("wait_beat1", {31'd0, cyc < 100}, 32'd1);
    enable     = 1'b0;
    seq_before = int'(exp_seq);
    pkt_before = exp_pkt;
    repeat (14) sink_cycle(1'b1);
    check("en_off_beats", (int'(exp_seq) - seq_before) & 32'hFF, 32'd3);
    check("en_off_valid", {31'd0, s.valid_out}, 32'd0);
    check("en_off_busy",  {31'd0, busy},        32'd0);
    check("en_off_count", {16'd0, pkt_count},   pkt_before + 1);
    check("en_off_total", {16'd0, pkt_count},   32'd301);

    // Restart, then reset during beat 2.
    enable = 1'b1;
    cyc = 0;
    while (!(s.valid_out && exp_beat == 2) && cyc < 20) begin
      sink_cycle(1'b1);
      cyc++;
    end
    check("wait_beat2", {31'd0, cyc < 20}, 32'd1);
    rst        = 1'b1;
    s.ready_in = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_valid", {31'd0, s.valid_out}, 32'd0);
    check("mid_rst_pkt",   {16'd0, pkt_count},   32'd0);
    check("mid_rst_busy",  {31'd0, busy},        32'd0);
    check("mid_rst_data",  {24'd0, s.data_out},  32'd0);
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check("restart_valid", {31'd0, s.valid_out}, 32'd1);
    check("restart_data",  {24'd0, s.data_out},  32'd0);

    // Gap sequence must replay from the seed (0,0,4,6,7,...).
    cyc = 0;
    while (exp_pkt < 6 && cyc < 200) begin
      sink_cycle(1'b1);
      cyc++;
    end
    check("restart_done",  {31'd0, exp_pkt == 6}, 32'd1);
    check("restart_count", {16'd0, pkt_count},    32'd6);
    check("restart_seq",   {24'd0, exp_seq},      32'd24);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
